hazard: RTL and testbench
=========================

# hazard

Pipeline interlock controller for the five-stage MIPS core. It is the stall/flush side of the bypass network: forwarding satisfies RAW dependences from MEM and WB, and this block handles every case forwarding cannot. Those cases are load-use dependences, reads of HI/LO while the multi-cycle multiply/divide unit is busy, data-memory wait states, and taken branches resolved in EX. It drives the stall and bubble controls of the IF/ID, ID/EX and EX/MEM pipeline registers and tracks multiply/divide occupancy with an internal counter.

## Interface
- ADDR_WIDTH, 5, register address width
- MUL_CYCLES, 4, multiply occupancy in cycles (≥1)
- DIV_CYCLES, 32, divide occupancy in cycles (≥1)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- reg_s_addr_id, reg_t_addr_id  in  ADDR_WIDTH  source registers of instruction in ID
- reg_s_re_id, reg_t_re_id  in  1  ID instruction actually reads rs / rt
- hilo_re_id  in  1  ID instruction is MFHI/MFLO
- muldiv_start_id  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- reg_d_we_ex  in  1  EX instruction writes a register
- reg_d_addr_ex  in  ADDR_WIDTH  EX destination register
- mem_re_ex  in  1  EX instruction is a load
- muldiv_start_ex  in  1  EX instruction launches multiply/divide
- muldiv_op_ex  in  1  0 = multiply, 1 = divide
- branch_taken_ex  in  1  taken branch/jump resolved in EX
- dmem_ready  in  1  data memory completes access this cycle
- stall_if, stall_id  out  1  hold PC / IF/ID register
- stall_ex, stall_mem  out  1  hold ID/EX / EX/MEM register
- flush_id  out  1  IF/ID loads a bubble
- flush_ex  out  1  ID/EX loads a bubble
- muldiv_busy  out  1  multiply/divide unit occupied
- muldiv_done  out  1  one-cycle pulse in last busy cycle

## Operation
- Freeze: when dmem_ready=0, assert all four stalls and suppress both flushes. The counter keeps running during a freeze.
- Load-use: the condition is mem_re_ex & reg_d_we_ex & reg_d_addr_ex≠0, and reg_d_addr_ex matches an ID source whose read-enable is set. Response: stall_if=stall_id=1, flush_ex=1.
- HI/LO interlock: the condition is hilo_re_id & (muldiv_busy | muldiv_start_ex). Response: stall_if=stall_id=1, flush_ex=1.
- Structural interlock: the condition is muldiv_start_id & (muldiv_busy | muldiv_start_ex). Response is the same as the HI/LO interlock.
- Branch: branch_taken_ex drives flush_id=flush_ex=1. It overrides load-use and the interlocks, since the ID instruction is wrong-path. All ID-side stalls are deasserted.
- Priority, highest first: rst, freeze, branch, load-use/interlocks.
- Counter FSM, IDLE/BUSY:
  - IDLE→BUSY on muldiv_start_ex when dmem_ready=1. The counter loads (muldiv_op_ex ? DIV_CYCLES : MUL_CYCLES) − 1.
  - BUSY decrements every cycle. At count 0 it returns to IDLE and asserts muldiv_done.
  - muldiv_start_ex while BUSY is illegal. It is ignored, and the bench asserts that it never occurs.
- muldiv_busy = (state==BUSY).
- Counter width is $clog2(max(MUL_CYCLES, DIV_CYCLES)). Reaching 0 never wraps below zero.

## Timing
- Stall/flush outputs are combinational from inputs and state. There is zero-cycle latency from a hazard to its stall.
- Reset, while rst=1: all outputs are 0, state=IDLE, counter=0. Reset during BUSY aborts the operation, and no muldiv_done is produced.
- Start accepted at edge k: muldiv_busy=1 for cycles k+1 … k+N, where N is the selected cycle count. muldiv_done=1 in cycle k+N. An MFHI waiting in ID advances at edge k+N.
- A load-use stall lasts exactly one cycle when dmem_ready=1: the load moves to MEM and the bubble enters EX.
- When freeze and branch coincide, the flush is deferred until the cycle in which dmem_ready=1. EX is held, so branch_taken_ex persists.

## Structure
- defines.vh holds the following constants:
  - HAZARD_IDLE/HAZARD_BUSY state encodings
  - MULDIV_OP_MUL/MULDIV_OP_DIV op encodings
- One sub-module is natural: hazard_muldiv_timer, containing the FSM, counter, busy and done.
- The top level keeps the combinational hazard detection and priority logic.

## Test plan
- Load-use: lw $3 in EX, ID reads rs=$3 with re=1. Expect stall_if=stall_id=flush_ex=1 for 1 cycle. Repeat with $0, or with re=0, and expect no stall.
- Divide then MFLO: DIV starts with DIV_CYCLES=32. Expect muldiv_busy high for 32 cycles, MFLO stalled for 33 cycles (includes the start cycle), and muldiv_done in the 32nd busy cycle.
- Back-to-back MULT: a second MULT in ID while the first is in EX stalls until busy drops. The second start is accepted and busy is high for 4 more cycles.
- Branch vs load-use: branch_taken_ex=1 together with a load-use match. Expect flush_id=flush_ex=1 and stall_if=stall_id=0.
- Memory freeze: dmem_ready=0 for 3 cycles during BUSY with a pending branch. Expect all stalls=1 and flushes=0, the counter advancing 3, and the flush in the first cycle after dmem_ready=1.
- Reset mid-divide: rst at busy cycle 10. Expect busy=0 the next cycle and no done pulse.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard controller: multiply/divide timer state
// encodings and the op encoding carried on muldiv_op_ex.
package hazard_pkg;

  // Multiply/divide occupancy timer states
  typedef enum logic {
    HAZARD_IDLE = 1'b0,
    HAZARD_BUSY = 1'b1
  } muldiv_state_e;

  // Operation selector seen on muldiv_op_ex
  localparam logic MULDIV_OP_MUL = 1'b0;
  localparam logic MULDIV_OP_DIV = 1'b1;

  // Larger of two occupancy figures, used to size the down-counter
  function automatic int max_cycles(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width for a given maximum occupancy; never narrower than one bit
  function automatic int cnt_width(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/hazard_muldiv_timer.sv
// Occupancy timer for the multi-cycle multiply/divide unit. A start loads
// the selected cycle count minus one; the unit stays busy until the count
// reaches zero, where it pulses done and returns to idle.
module hazard_muldiv_timer
  import hazard_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic op,
  output logic busy_raw,
  output logic busy,
  output logic done
);

  localparam int MAX_CYC = max_cycles(MUL_CYCLES, DIV_CYCLES);
  localparam int CNT_W   = cnt_width(MAX_CYC);

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  muldiv_state_e    state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next-state and counter update; a start seen while busy is ignored
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      HAZARD_IDLE: begin
        if (start) begin
          state_d = HAZARD_BUSY;
          count_d = (op == MULDIV_OP_DIV) ? DIV_LOAD : MUL_LOAD;
        end
      end
      HAZARD_BUSY: begin
        if (count_q == '0) begin
          state_d = HAZARD_IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: begin
        state_d = HAZARD_IDLE;
        count_d = '0;
      end
    endcase
  end

  // State and counter registers with synchronous reset (aborts any operation)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HAZARD_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Busy/done outputs, forced low for as long as reset is held
  always_comb begin
    busy_raw = (state_q == HAZARD_BUSY);
    busy     = busy_raw & ~rst;
    done     = busy & (count_q == '0);
  end

endmodule

// File: rtl/hazard.sv
// Pipeline interlock controller: detects the hazards forwarding cannot cover
// (load-use, HI/LO reads and multiply/divide restarts while the unit is busy,
// data-memory wait states, taken branches) and drives stall/flush controls.
module hazard
  import hazard_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] reg_s_addr_id,
  input  logic [ADDR_WIDTH-1:0] reg_t_addr_id,
  input  logic                  reg_s_re_id,
  input  logic                  reg_t_re_id,
  input  logic                  hilo_re_id,
  input  logic                  muldiv_start_id,
  input  logic                  reg_d_we_ex,
  input  logic [ADDR_WIDTH-1:0] reg_d_addr_ex,
  input  logic                  mem_re_ex,
  input  logic                  muldiv_start_ex,
  input  logic                  muldiv_op_ex,
  input  logic                  branch_taken_ex,
  input  logic                  dmem_ready,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  stall_mem,
  output logic                  flush_id,
  output logic                  flush_ex,
  output logic                  muldiv_busy,
  output logic                  muldiv_done
);

  logic busy_raw;
  logic timer_start;
  logic load_use;
  logic hilo_hazard;
  logic struct_hazard;
  logic id_interlock;
  logic rs_match;
  logic rt_match;

  // The timer only accepts a launch while memory is not holding the pipe
  assign timer_start = muldiv_start_ex & dmem_ready;

  hazard_muldiv_timer #(
    .MUL_CYCLES (MUL_CYCLES),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (timer_start),
    .op       (muldiv_op_ex),
    .busy_raw (busy_raw),
    .busy     (muldiv_busy),
    .done     (muldiv_done)
  );

  // Hazard detection: load-use on either source, HI/LO and unit-restart interlocks
  always_comb begin
    rs_match      = reg_s_re_id & (reg_s_addr_id == reg_d_addr_ex);
    rt_match      = reg_t_re_id & (reg_t_addr_id == reg_d_addr_ex);
    load_use      = mem_re_ex & reg_d_we_ex & (reg_d_addr_ex != '0) & (rs_match | rt_match);
    hilo_hazard   = hilo_re_id & (busy_raw | muldiv_start_ex);
    struct_hazard = muldiv_start_id & (busy_raw | muldiv_start_ex);
    id_interlock  = load_use | hilo_hazard | struct_hazard;
  end

  // Priority resolution: reset, memory freeze, taken branch, then ID interlocks
  always_comb begin
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    if (rst) begin
      stall_if = 1'b0;
    end else if (!dmem_ready) begin
      stall_if  = 1'b1;
      stall_id  = 1'b1;
      stall_ex  = 1'b1;
      stall_mem = 1'b1;
    end else if (branch_taken_ex) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else if (id_interlock) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
      flush_ex = 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard.sv
// Directed bench for the hazard controller: reset, load-use, divide/MFLO,
// back-to-back multiply, branch priority, memory freeze and reset mid-divide.
module tb_hazard;

  logic       clk;
  logic       rst;
  logic [4:0] reg_s_addr_id;
  logic [4:0] reg_t_addr_id;
  logic       reg_s_re_id;
  logic       reg_t_re_id;
  logic       hilo_re_id;
  logic       muldiv_start_id;
  logic       reg_d_we_ex;
  logic [4:0] reg_d_addr_ex;
  logic       mem_re_ex;
  logic       muldiv_start_ex;
  logic       muldiv_op_ex;
  logic       branch_taken_ex;
  logic       dmem_ready;
  logic       stall_if;
  logic       stall_id;
  logic       stall_ex;
  logic       stall_mem;
  logic       flush_id;
  logic       flush_ex;
  logic       muldiv_busy;
  logic       muldiv_done;

  int total;
  int bad;

  // Output vector order: stall_if stall_id stall_ex stall_mem flush_id flush_ex busy done
  localparam logic [7:0] EXP_NONE   = 8'b0000_0000;
  localparam logic [7:0] EXP_ID     = 8'b1100_0100;
  localparam logic [7:0] EXP_ID_B   = 8'b1100_0110;
  localparam logic [7:0] EXP_ID_D   = 8'b1100_0111;
  localparam logic [7:0] EXP_BRANCH = 8'b0000_1100;
  localparam logic [7:0] EXP_BUSY   = 8'b0000_0010;
  localparam logic [7:0] EXP_DONE   = 8'b0000_0011;
  localparam logic [7:0] EXP_FRZ    = 8'b1111_0000;
  localparam logic [7:0] EXP_FRZ_B  = 8'b1111_0010;
  localparam logic [7:0] EXP_BR_D   = 8'b0000_1111;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       rs_re;
    logic       rt_re;
    logic       hilo;
    logic       start_id;
    logic       we_ex;
    logic [4:0] d_ex;
    logic       mem_re;
    logic       start_ex;
    logic       op;
    logic       br;
    logic       ready;
  } stim_t;

  hazard #(
    .ADDR_WIDTH (5),
    .MUL_CYCLES (4),
    .DIV_CYCLES (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .reg_s_addr_id   (reg_s_addr_id),
    .reg_t_addr_id   (reg_t_addr_id),
    .reg_s_re_id     (reg_s_re_id),
    .reg_t_re_id     (reg_t_re_id),
    .hilo_re_id      (hilo_re_id),
    .muldiv_start_id (muldiv_start_id),
    .reg_d_we_ex     (reg_d_we_ex),
    .reg_d_addr_ex   (reg_d_addr_ex),
    .mem_re_ex       (mem_re_ex),
    .muldiv_start_ex (muldiv_start_ex),
    .muldiv_op_ex    (muldiv_op_ex),
    .branch_taken_ex (branch_taken_ex),
    .dmem_ready      (dmem_ready),
    .stall_if        (stall_if),
    .stall_id        (stall_id),
    .stall_ex        (stall_ex),
    .stall_mem       (stall_mem),
    .flush_id        (flush_id),
    .flush_ex        (flush_ex),
    .muldiv_busy     (muldiv_busy),
    .muldiv_done     (muldiv_done)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Idle pipeline: nothing hazardous, memory ready
  function automatic stim_t idleStim();
    stim_t s;
    s       = '0;
    s.ready = 1'b1;
    return s;
  endfunction

  task automatic driveInputs(input stim_t s);
    rst             = s.rst;
    reg_s_addr_id   = s.rs;
    reg_t_addr_id   = s.rt;
    reg_s_re_id     = s.rs_re;
    reg_t_re_id     = s.rt_re;
    hilo_re_id      = s.hilo;
    muldiv_start_id = s.start_id;
    reg_d_we_ex     = s.we_ex;
    reg_d_addr_ex   = s.d_ex;
    mem_re_ex       = s.mem_re;
    muldiv_start_ex = s.start_ex;
    muldiv_op_ex    = s.op;
    branch_taken_ex = s.br;
    dmem_ready      = s.ready;
  endtask

  // Advance to the next cycle, drive one vector, let combinational outputs settle
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    driveInputs(s);
    #3;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] expected);
    logic [7:0] observed;
    observed = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, muldiv_busy, muldiv_done};
    total++;
    assert (observed === expected)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Stimulus guard: a launch in EX while the unit is busy is never driven
  always @(negedge clk) begin
    if (!rst && muldiv_start_ex && muldiv_busy) begin
      bad++;
      $error("[TB] FAIL start_while_busy observed=1 expected=0");
    end
  end

  initial begin
    stim_t s;
    total = 0;
    bad   = 0;

    // Reset with hazards present: every output held low
    s       = idleStim();
    s.rst   = 1'b1;
    s.br    = 1'b1;
    s.ready = 1'b0;
    driveInputs(s);
    #4;
    checkOutput("reset_freeze_branch", EXP_NONE);
    s.ready = 1'b1; s.br = 1'b0; s.hilo = 1'b1; s.start_ex = 1'b1;
    applyStimulus(s);
    checkOutput("reset_hilo_start", EXP_NONE);

    s = idleStim();
    applyStimulus(s);
    checkOutput("idle_after_reset", EXP_NONE);

    // Load-use on rs, then the load has moved on
    s = idleStim();
    s.mem_re = 1'b1; s.we_ex = 1'b1; s.d_ex = 5'd3; s.rs = 5'd3; s.rs_re = 1'b1;
    applyStimulus(s);
    checkOutput("load_use_rs", EXP_ID);
    s = idleStim();
    s.rs = 5'd3; s.rs_re = 1'b1;
    applyStimulus(s);
    checkOutput("load_use_cleared", EXP_NONE);

    // Load-use on rt
    s = idleStim();
    s.mem_re = 1'b1; s.we_ex = 1'b1; s.d_ex = 5'd9; s.rs = 5'd4; s.rs_re = 1'b1;
    s.rt = 5'd9; s.rt_re = 1'b1;
    applyStimulus(s);
    checkOutput("load_use_rt", EXP_ID);

    // Load to $0 never stalls
    s = idleStim();
    s.mem_re = 1'b1; s.we_ex = 1'b1; s.d_ex = 5'd0; s.rs = 5'd0; s.rs_re = 1'b1;
    applyStimulus(s);
    checkOutput("load_use_r0", EXP_NONE);

    // Matching address but the source is not read
    s = idleStim();
    s.mem_re = 1'b1; s.we_ex = 1'b1; s.d_ex = 5'd3; s.rs = 5'd3; s.rt = 5'd3;
    applyStimulus(s);
    checkOutput("load_use_no_re", EXP_NONE);

    // Branch overrides a simultaneous load-use
    s = idleStim();
    s.mem_re = 1'b1; s.we_ex = 1'b1; s.d_ex = 5'd3; s.rs = 5'd3; s.rs_re = 1'b1; s.br = 1'b1;
    applyStimulus(s);
    checkOutput("branch_over_load_use", EXP_BRANCH);

    // DIV launches in EX with MFLO in ID: 1 start cycle + 32 busy cycles stalled
    s = idleStim();
    s.start_ex = 1'b1; s.op = 1'b1; s.hilo = 1'b1;
    applyStimulus(s);
    checkOutput("div_start_mflo", EXP_ID);
    s = idleStim();
    s.hilo = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      applyStimulus(s);
      checkOutput($sformatf("div_busy_%0d", i), EXP_ID_B);
    end
    applyStimulus(s);
    checkOutput("div_done_32", EXP_ID_D);
    applyStimulus(s);
    checkOutput("mflo_released", EXP_NONE);

    // Back-to-back MULT: second waits in ID through the first
    s = idleStim();
    s.start_ex = 1'b1; s.start_id = 1'b1;
    applyStimulus(s);
    checkOutput("mult2_start_cycle", EXP_ID);
    s = idleStim();
    s.start_id = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(s);
      checkOutput($sformatf("mult2_wait_%0d", i), EXP_ID_B);
    end
    applyStimulus(s);
    checkOutput("mult2_wait_done", EXP_ID_D);
    s = idleStim();
    s.start_ex = 1'b1;
    applyStimulus(s);
    checkOutput("mult2_launch", EXP_NONE);
    s = idleStim();
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(s);
      checkOutput($sformatf("mult2_busy_%0d", i), EXP_BUSY);
    end
    applyStimulus(s);
    checkOutput("mult2_done", EXP_DONE);
    applyStimulus(s);
    checkOutput("mult2_idle", EXP_NONE);

    // Memory freeze for 3 busy cycles with a pending branch; counter keeps going
    s = idleStim();
    s.start_ex = 1'b1;
    applyStimulus(s);
    checkOutput("frz_mult_launch", EXP_NONE);
    s = idleStim();
    s.br = 1'b1; s.ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(s);
      checkOutput($sformatf("frz_cycle_%0d", i), EXP_FRZ_B);
    end
    s.ready = 1'b1;
    applyStimulus(s);
    checkOutput("frz_branch_flush_done", EXP_BR_D);
    s = idleStim();
    applyStimulus(s);
    checkOutput("frz_after", EXP_NONE);

    // A launch during a freeze is not accepted
    s = idleStim();
    s.start_ex = 1'b1; s.ready = 1'b0;
    applyStimulus(s);
    checkOutput("start_frozen", EXP_FRZ);
    s = idleStim();
    applyStimulus(s);
    checkOutput("start_frozen_ignored", EXP_NONE);

    // Reset at busy cycle 10 of a divide: no busy, no done afterwards
    s = idleStim();
    s.start_ex = 1'b1; s.op = 1'b1;
    applyStimulus(s);
    checkOutput("rdiv_launch", EXP_NONE);
    s = idleStim();
    for (int i = 1; i <= 9; i++) begin
      applyStimulus(s);
      checkOutput($sformatf("rdiv_busy_%0d", i), EXP_BUSY);
    end
    s.rst = 1'b1;
    applyStimulus(s);
    checkOutput("rdiv_reset_cycle", EXP_NONE);
    s = idleStim();
    for (int i = 1; i <= 30; i++) begin
      applyStimulus(s);
      checkOutput($sformatf("rdiv_after_%0d", i), EXP_NONE);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog so the run always ends on its own
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
